dilithium_verify_sequencer: RTL

Hardware front-end for the dilithium core in verify mode, replacing the bench-driven load sequence.
- Accepts a verify request (message length) plus a host word stream already in core order.
- Resets and starts the core, then passes host words through with segment counting.
- Injects the message-length word itself, collects the result word and reports accept/reject.
- Sits directly upstream of dilithium on its data_i/valid_i/ready_i side and downstream on data_o/valid_o/ready_o.

---
 rtl/dilithium_seq_pkg.sv | 88 ++++++++
 rtl/dilithium_verify_sequencer_if.sv | 27 ++
 rtl/dilithium_seq_seg_ctr.sv | 43 ++++
 rtl/dilithium_verify_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_seq_pkg.sv
// Shared types, per-security-level sizes and segment sequencing helpers for the
// dilithium verify sequencer.
package dilithium_seq_pkg;

  typedef enum logic [2:0] {
    SEG_RHO  = 3'd0,
    SEG_C    = 3'd1,
    SEG_Z    = 3'd2,
    SEG_T1   = 3'd3,
    SEG_MLEN = 3'd4,
    SEG_MSG  = 3'd5,
    SEG_H    = 3'd6
  } seg_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CRST   = 3'd1,
    ST_START  = 3'd2,
    ST_SEG    = 3'd3,
    ST_RESULT = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int unsigned RHO_BITS = 32'd256;
  localparam int unsigned C_BITS   = 32'd256;

  function automatic int unsigned z_bits(input int unsigned sec);
    case (sec)
      32'd3:   return 32'd25600;
      32'd5:   return 32'd35840;
      default: return 32'd18432;
    endcase
  endfunction

  function automatic int unsigned h_bits(input int unsigned sec);
    case (sec)
      32'd3:   return 32'd488;
      32'd5:   return 32'd664;
      default: return 32'd672;
    endcase
  endfunction

  function automatic int unsigned t1_bits(input int unsigned sec);
    case (sec)
      32'd3:   return 32'd15360;
      32'd5:   return 32'd20480;
      default: return 32'd10240;
    endcase
  endfunction

  function automatic int unsigned words(input int unsigned bits, input int unsigned w);
    return (bits + w - 32'd1) / w;
  endfunction

  // The two core variants consume the same segments in different orders.
  function automatic seg_t next_seg(input seg_t seg, input logic hp);
    if (hp) begin
      case (seg)
        SEG_RHO:  return SEG_C;
        SEG_C:    return SEG_Z;
        SEG_Z:    return SEG_T1;
        SEG_T1:   return SEG_MLEN;
        SEG_MLEN: return SEG_MSG;
        SEG_MSG:  return SEG_H;
        default:  return SEG_H;
      endcase
    end else begin
      case (seg)
        SEG_RHO:  return SEG_T1;
        SEG_T1:   return SEG_C;
        SEG_C:    return SEG_Z;
        SEG_Z:    return SEG_H;
        SEG_H:    return SEG_MLEN;
        SEG_MLEN: return SEG_MSG;
        default:  return SEG_MSG;
      endcase
    end
  endfunction

  function automatic logic is_last_seg(input seg_t seg, input logic hp);
    if (hp) begin
      return (seg == SEG_H);
    end else begin
      return (seg == SEG_MSG);
    end
  endfunction

endpackage

// File: rtl/dilithium_verify_sequencer_if.sv
// Host word stream and dilithium core handshake bundle; master is the sequencer side.
interface dilithium_verify_sequencer_if #(
  parameter int unsigned W = 64
);
  logic         h_valid_i;
  logic         h_ready_o;
  logic [W-1:0] h_data_i;
  logic         core_rst;
  logic         core_start;
  logic [1:0]   core_mode;
  logic         core_valid_i;
  logic         core_ready_i;
  logic [W-1:0] core_data_i;
  logic         core_valid_o;
  logic         core_ready_o;
  logic [W-1:0] core_data_o;

  modport master (
    input  h_valid_i, h_data_i, core_ready_i, core_valid_o, core_data_o,
    output h_ready_o, core_rst, core_start, core_mode, core_valid_i, core_data_i, core_ready_o
  );

  modport slave (
    output h_valid_i, h_data_i, core_ready_i, core_valid_o, core_data_o,
    input  h_ready_o, core_rst, core_start, core_mode, core_valid_i, core_data_i, core_ready_o
  );
endinterface

// File: rtl/dilithium_seq_seg_ctr.sv
// Word counter that wraps to zero on the terminal transfer; last_o flags the final
// word of the current terminal count.
module dilithium_seq_seg_ctr #(
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [CW-1:0] tc_i,
  output logic          last_o
);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == (tc_i - ONE));

  // Next count: clear, wrap on terminal word, or step
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (last_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/dilithium_verify_sequencer.sv
// Verify-mode front-end for the dilithium core: resets/starts the core, streams host
// segments, injects the message length and reports the result. Optional cycle counter
// enabled by DILITHIUM_SEQ_CYCLE_CNT_EN.
module dilithium_verify_sequencer
  import dilithium_seq_pkg::*;
#(
  parameter int unsigned HIGH_PERF     = 1,
  parameter int unsigned SEC_LEVEL     = 2,
  parameter int unsigned MAX_MSG_BYTES = 3300,
  parameter int unsigned RST_CYCLES    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_i,
  input  logic [$clog2(MAX_MSG_BYTES*8):0]    msg_len_i,
  output logic                                busy_o,
  dilithium_verify_sequencer_if.master        bus,
  output logic                                done_o,
  output logic                                accept_o,
  output logic                                err_o
`ifdef DILITHIUM_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]                         cycles_o
`endif
);
  localparam int unsigned W    = (HIGH_PERF != 0) ? 32'd64 : 32'd32;
  localparam int unsigned ML_W = $clog2(MAX_MSG_BYTES*8) + 1;
  localparam int unsigned CW   = 32;
  localparam int unsigned WSH  = $clog2(W);
  localparam logic        HP   = (HIGH_PERF != 0);

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] W_M1      = CW'(W - 32'd1);
  localparam logic [CW-1:0] RST_TC    = CW'(RST_CYCLES);
  localparam logic [CW-1:0] RHO_WORDS = CW'(words(RHO_BITS, W));
  localparam logic [CW-1:0] C_WORDS   = CW'(words(C_BITS, W));
  localparam logic [CW-1:0] Z_WORDS   = CW'(words(z_bits(SEC_LEVEL), W));
  localparam logic [CW-1:0] T1_WORDS  = CW'(words(t1_bits(SEC_LEVEL), W));
  localparam logic [CW-1:0] H_WORDS   = CW'(words(h_bits(SEC_LEVEL), W));

  state_t            state_q, state_d;
  seg_t              seg_q, seg_d;
  logic [ML_W-1:0]   msg_len_q;
  logic [CW-1:0]     msg_words_q;
  logic              pend_acc_q, pend_err_q;
  logic              busy_q, done_q, accept_q, err_q;
  logic              core_rst_q, core_start_q, core_ready_q;

  logic              len_err_s, xfer_s, h_ready_s, core_valid_s;
  logic [W-1:0]      core_data_s;
  logic              ctr_clr_s, ctr_inc_s, ctr_last_s;
  logic [CW-1:0]     ctr_tc_s, seg_words_s;
  logic [CW-1:0]     msg_bits_s, msg_words_raw_s, msg_words_s;

  assign len_err_s       = (msg_len_i > ML_W'(MAX_MSG_BYTES));
  assign msg_bits_s      = {{(CW-ML_W-3){1'b0}}, msg_len_i, 3'b000};
  assign msg_words_raw_s = (msg_bits_s + W_M1) >> WSH;
  // A zero-length message still occupies one word on the core input
  assign msg_words_s     = (msg_words_raw_s == '0) ? ONE : msg_words_raw_s;
  assign ctr_clr_s       = (state_q == ST_IDLE);

  dilithium_seq_seg_ctr #(.CW(CW)) u_seg_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ctr_clr_s),
    .inc_i  (ctr_inc_s),
    .tc_i   (ctr_tc_s),
    .last_o (ctr_last_s)
  );

  // Word count of the active segment
  always_comb begin
    seg_words_s = ONE;
    case (seg_q)
      SEG_RHO:  seg_words_s = RHO_WORDS;
      SEG_C:    seg_words_s = C_WORDS;
      SEG_Z:    seg_words_s = Z_WORDS;
      SEG_T1:   seg_words_s = T1_WORDS;
      SEG_MLEN: seg_words_s = ONE;
      SEG_MSG:  seg_words_s = msg_words_q;
      SEG_H:    seg_words_s = H_WORDS;
      default:  seg_words_s = ONE;
    endcase
  end

  // Next-state logic and zero-latency data path
  always_comb begin
    state_d      = state_q;
    seg_d        = seg_q;
    h_ready_s    = 1'b0;
    core_valid_s = 1'b0;
    core_data_s  = '0;
    xfer_s       = 1'b0;
    ctr_inc_s    = 1'b0;
    ctr_tc_s     = seg_words_s;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (len_err_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CRST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CRST: begin
        ctr_inc_s = 1'b1;
        ctr_tc_s  = RST_TC;
        if (ctr_last_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_CRST;
        end
      end
      ST_START: begin
        seg_d   = SEG_RHO;
        state_d = ST_SEG;
      end
      ST_SEG: begin
        if (seg_q == SEG_MLEN) begin
          core_valid_s = 1'b1;
          core_data_s  = {{(W-ML_W){1'b0}}, msg_len_q};
          xfer_s       = bus.core_ready_i;
        end else begin
          core_valid_s = bus.h_valid_i;
          core_data_s  = bus.h_data_i;
          h_ready_s    = bus.core_ready_i;
          xfer_s       = bus.h_valid_i & bus.core_ready_i;
        end
        ctr_inc_s = xfer_s;
        if (xfer_s && ctr_last_s) begin
          if (is_last_seg(seg_q, HP)) begin
            state_d = ST_RESULT;
          end else begin
            seg_d = next_seg(seg_q, HP);
          end
        end else begin
          state_d = ST_SEG;
        end
      end
      ST_RESULT: begin
        if (bus.core_valid_o) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        seg_d   = SEG_RHO;
      end
    endcase
  end

  // Control-state registers; core control lines are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      seg_q        <= SEG_RHO;
      busy_q       <= 1'b0;
      core_rst_q   <= 1'b0;
      core_start_q <= 1'b0;
      core_ready_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_q        <= seg_d;
      busy_q       <= (state_d != ST_IDLE);
      core_rst_q   <= (state_d == ST_CRST);
      core_start_q <= (state_d == ST_START);
      core_ready_q <= (state_d == ST_RESULT);
      done_q       <= (state_q == ST_DONE);
    end
  end

  // Request latch and result reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_len_q   <= '0;
      msg_words_q <= '0;
      pend_acc_q  <= 1'b0;
      pend_err_q  <= 1'b0;
      accept_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && req_i) begin
        msg_len_q   <= msg_len_i;
        msg_words_q <= msg_words_s;
        pend_err_q  <= len_err_s;
        pend_acc_q  <= 1'b0;
        accept_q    <= 1'b0;
        err_q       <= 1'b0;
      end else if ((state_q == ST_RESULT) && bus.core_valid_o) begin
        pend_acc_q <= (bus.core_data_o == '0);
      end else if (state_q == ST_DONE) begin
        accept_q <= pend_acc_q;
        err_q    <= pend_err_q;
      end else begin
        pend_acc_q <= pend_acc_q;
      end
    end
  end

`ifdef DILITHIUM_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_q;
  logic        cyc_en_s;

  assign cyc_en_s = (state_q == ST_START) || (state_q == ST_SEG) || (state_q == ST_RESULT) ||
                    (state_q == ST_DONE) || (done_q && !err_q);

  // Saturating run-time counter, cleared by an accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 32'd0;
    end else if ((state_q == ST_IDLE) && req_i) begin
      cyc_q <= 32'd0;
    end else if (cyc_en_s && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end else begin
      cyc_q <= cyc_q;
    end
  end

  assign cycles_o = cyc_q;
`endif

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign accept_o          = accept_q;
  assign err_o             = err_q;
  assign bus.core_rst      = core_rst_q;
  assign bus.core_start    = core_start_q;
  assign bus.core_mode     = 2'd1;
  assign bus.core_ready_o  = core_ready_q;
  assign bus.core_valid_i  = core_valid_s;
  assign bus.core_data_i   = core_data_s;
  assign bus.h_ready_o     = h_ready_s;
endmodule
